// File: rtl/gcd_arbiter.sv
// gcd_arbiter
// Round-robin arbiter and sequencer that shares a single gcd unit among
// num_req_p requesters. One operand pair is accepted at a time, issued to the
// gcd unit over its valid/ready handshake, and the result is consumed with
// yumi and returned to the originating requester. The number of cycles the
// last operation spent waiting on the gcd unit is reported (saturating).
//
// Ports:
//   clk_i          - clock
//   reset_n_i      - synchronous active-low reset
//   req_v_i        - per-requester operand valid
//   req_a_i/req_b_i- packed operands, requester i at [i*width_p +: width_p]
//   req_ready_o    - one-hot grant (combinational, IDLE only)
//   resp_v_o       - one-hot result valid
//   resp_data_o    - shared result
//   resp_yumi_i    - per-requester result consume
//   gcd_ready_i    - gcd unit idle
//   gcd_v_o        - operands valid to gcd
//   gcd_a_o/gcd_b_o- operands to gcd
//   gcd_v_i        - gcd result valid
//   gcd_data_i     - gcd result
//   gcd_yumi_o     - consume gcd result (same cycle as gcd_v_i in WAIT)
//   busy_o         - high whenever not IDLE
//   owner_o        - current or last granted requester
//   last_cycles_o  - WAIT cycles of the last operation, saturating at 0xFFFF
module gcd_arbiter #(
    parameter int num_req_p = 4,
    parameter int width_p   = 32,
    parameter int lg_req_p  = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic [num_req_p-1:0]           req_v_i,
    input  logic [num_req_p*width_p-1:0]   req_a_i,
    input  logic [num_req_p*width_p-1:0]   req_b_i,
    output logic [num_req_p-1:0]           req_ready_o,
    output logic [num_req_p-1:0]           resp_v_o,
    output logic [width_p-1:0]             resp_data_o,
    input  logic [num_req_p-1:0]           resp_yumi_i,
    input  logic                           gcd_ready_i,
    output logic                           gcd_v_o,
    output logic [width_p-1:0]             gcd_a_o,
    output logic [width_p-1:0]             gcd_b_o,
    input  logic                           gcd_v_i,
    input  logic [width_p-1:0]             gcd_data_i,
    output logic                           gcd_yumi_o,
    output logic                           busy_o,
    output logic [lg_req_p-1:0]            owner_o,
    output logic [15:0]                    last_cycles_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    state_e                  state_r;
    logic [lg_req_p-1:0]     ptr_r;
    logic [lg_req_p-1:0]     owner_r;
    logic [width_p-1:0]      a_r;
    logic [width_p-1:0]      b_r;
    logic [width_p-1:0]      result_r;
    logic [15:0]             cnt_r;
    logic [15:0]             last_cycles_r;
    logic                    gcd_v_r;
    logic                    busy_r;
    logic [num_req_p-1:0]    resp_v_r;

    logic                    grant_found_s;
    logic [lg_req_p-1:0]     grant_idx_s;
    logic [31:0]             grant_off_s;
    logic [width_p-1:0]      sel_a_s;
    logic [width_p-1:0]      sel_b_s;
    logic [num_req_p-1:0]    req_ready_s;
    logic                    gcd_yumi_s;
    logic [15:0]             cnt_inc_s;

    // Index arithmetic modulo num_req_p; base is always a valid index, so a
    // single conditional subtract is enough for offsets below num_req_p.
    function automatic logic [lg_req_p-1:0] wrap_add(input logic [lg_req_p-1:0] base,
                                                     input logic [31:0]         off);
        logic [31:0] sum_v;
        sum_v = 32'(base) + off;
        if (sum_v >= 32'(num_req_p)) begin
            sum_v = sum_v - 32'(num_req_p);
        end else begin
            sum_v = sum_v;
        end
        return sum_v[lg_req_p-1:0];
    endfunction

    function automatic logic [num_req_p-1:0] one_hot(input logic [lg_req_p-1:0] idx);
        logic [num_req_p-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Round-robin search: first valid requester at or above ptr, wrapping.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        for (int unsigned k = 0; k < num_req_p; k++) begin
            if (!grant_found_s && req_v_i[wrap_add(ptr_r, 32'(k))]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = wrap_add(ptr_r, 32'(k));
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Operand mux for the granted requester.
    always_comb begin
        grant_off_s = 32'(grant_idx_s) * 32'(width_p);
        sel_a_s     = req_a_i[grant_off_s +: width_p];
        sel_b_s     = req_b_i[grant_off_s +: width_p];
    end

    // Grant is only offered in IDLE and never while reset is asserted.
    always_comb begin
        req_ready_s = '0;
        if (reset_n_i && (state_r == ST_IDLE) && grant_found_s) begin
            req_ready_s = one_hot(grant_idx_s);
        end else begin
            req_ready_s = '0;
        end
    end

    // gcd result is consumed in the very cycle it is presented during WAIT.
    always_comb begin
        gcd_yumi_s = 1'b0;
        if (reset_n_i && (state_r == ST_WAIT) && gcd_v_i) begin
            gcd_yumi_s = 1'b1;
        end else begin
            gcd_yumi_s = 1'b0;
        end
    end

    // Saturating WAIT-cycle counter increment.
    always_comb begin
        cnt_inc_s = 16'd0;
        if (cnt_r == 16'hFFFF) begin
            cnt_inc_s = 16'hFFFF;
        end else begin
            cnt_inc_s = cnt_r + 16'd1;
        end
    end

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_r       <= ST_IDLE;
            ptr_r         <= '0;
            owner_r       <= '0;
            a_r           <= '0;
            b_r           <= '0;
            result_r      <= '0;
            cnt_r         <= 16'd0;
            last_cycles_r <= 16'd0;
            gcd_v_r       <= 1'b0;
            busy_r        <= 1'b0;
            resp_v_r      <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_found_s) begin
                        owner_r <= grant_idx_s;
                        a_r     <= sel_a_s;
                        b_r     <= sel_b_s;
                        gcd_v_r <= 1'b1;
                        busy_r  <= 1'b1;
                        state_r <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (gcd_ready_i) begin
                        gcd_v_r <= 1'b0;
                        cnt_r   <= 16'd0;
                        state_r <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    cnt_r <= cnt_inc_s;
                    if (gcd_v_i) begin
                        result_r      <= gcd_data_i;
                        last_cycles_r <= cnt_inc_s;
                        resp_v_r      <= one_hot(owner_r);
                        state_r       <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (resp_yumi_i[owner_r]) begin
                        resp_v_r <= '0;
                        ptr_r    <= wrap_add(owner_r, 32'd1);
                        busy_r   <= 1'b0;
                        state_r  <= ST_IDLE;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    gcd_v_r  <= 1'b0;
                    busy_r   <= 1'b0;
                    resp_v_r <= '0;
                end
            endcase
        end
    end

    assign req_ready_o   = req_ready_s;
    assign resp_v_o      = resp_v_r;
    assign resp_data_o   = result_r;
    assign gcd_v_o       = gcd_v_r;
    assign gcd_a_o       = a_r;
    assign gcd_b_o       = b_r;
    assign gcd_yumi_o    = gcd_yumi_s;
    assign busy_o        = busy_r;
    assign owner_o       = owner_r;
    assign last_cycles_o = last_cycles_r;

endmodule

// File: tb/tb_gcd_arbiter.sv
// Self-checking bench for gcd_arbiter: table-driven vectors, hand-written
// corner sequences and randomized traffic against a transaction-level
// round-robin/Euclid reference. A small behavioural gcd unit answers the
// arbiter with configurable stall and compute delay.
module tb_gcd_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int LG = 2;

    logic             clk;
    logic             reset_n_i;
    logic [N-1:0]     req_v_i;
    logic [N*W-1:0]   req_a_i;
    logic [N*W-1:0]   req_b_i;
    logic [N-1:0]     req_ready_o;
    logic [N-1:0]     resp_v_o;
    logic [W-1:0]     resp_data_o;
    logic [N-1:0]     resp_yumi_i;
    logic             gcd_ready_i;
    logic             gcd_v_o;
    logic [W-1:0]     gcd_a_o;
    logic [W-1:0]     gcd_b_o;
    logic             gcd_v_i;
    logic [W-1:0]     gcd_data_i;
    logic             gcd_yumi_o;
    logic             busy_o;
    logic [LG-1:0]    owner_o;
    logic [15:0]      last_cycles_o;

    gcd_arbiter #(.num_req_p(N), .width_p(W)) dut (
        .clk_i(clk), .reset_n_i(reset_n_i),
        .req_v_i(req_v_i), .req_a_i(req_a_i), .req_b_i(req_b_i),
        .req_ready_o(req_ready_o), .resp_v_o(resp_v_o), .resp_data_o(resp_data_o),
        .resp_yumi_i(resp_yumi_i), .gcd_ready_i(gcd_ready_i), .gcd_v_o(gcd_v_o),
        .gcd_a_o(gcd_a_o), .gcd_b_o(gcd_b_o), .gcd_v_i(gcd_v_i),
        .gcd_data_i(gcd_data_i), .gcd_yumi_o(gcd_yumi_o), .busy_o(busy_o),
        .owner_o(owner_o), .last_cycles_o(last_cycles_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int fails  = 0;

    // requester-side state and reference round-robin pointer
    logic [N-1:0] pend_v;
    logic [W-1:0] pend_a [N];
    logic [W-1:0] pend_b [N];
    int           ptr_m;

    // gcd unit model configuration and state
    int           delay_cfg;
    int           stall_cfg;
    int           stall_cnt;
    int           m_delay;
    bit           m_busy;
    bit           m_done;
    logic [W-1:0] m_res;

    typedef struct {
        int         req;
        logic [W-1:0] a;
        logic [W-1:0] b;
        int         dly;
        int         stl;
        logic [W-1:0] res;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] p, q, t;
        p = x;
        q = y;
        while (q != '0) begin
            t = p % q;
            p = q;
            q = t;
        end
        return p;
    endfunction

    function automatic int rr_pick();
        for (int k = 0; k < N; k++) begin
            if (pend_v[(ptr_m + k) % N]) return (ptr_m + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] oh_of(input int i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic drive_reqs();
        for (int i = 0; i < N; i++) begin
            req_v_i[i]         = pend_v[i];
            req_a_i[i*W +: W]  = pend_a[i];
            req_b_i[i*W +: W]  = pend_b[i];
        end
    endtask

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        pend_v[i] = 1'b1;
        pend_a[i] = a;
        pend_b[i] = b;
    endtask

    // Behavioural gcd unit: optional stall before accepting, then a fixed
    // compute delay before presenting the result until it is consumed.
    initial begin
        gcd_ready_i = 1'b0;
        gcd_v_i     = 1'b0;
        gcd_data_i  = '0;
        m_busy = 1'b0; m_done = 1'b0; m_delay = 0; stall_cnt = 0; m_res = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!reset_n_i) begin
                m_busy = 1'b0; m_done = 1'b0; m_delay = 0; stall_cnt = 0;
                gcd_v_i = 1'b0; gcd_ready_i = 1'b0;
            end else if (m_busy) begin
                gcd_ready_i = 1'b0;
                if (m_done) begin
                    m_busy = 1'b0; m_done = 1'b0; gcd_v_i = 1'b0;
                end else if (m_delay > 0) begin
                    m_delay--;
                    gcd_v_i = 1'b0;
                end else begin
                    gcd_v_i    = 1'b1;
                    gcd_data_i = m_res;
                    #1;
                    if (gcd_yumi_o) m_done = 1'b1;
                end
            end else begin
                gcd_v_i = 1'b0;
                if (gcd_v_o) begin
                    if (stall_cnt < stall_cfg) begin
                        stall_cnt++;
                        gcd_ready_i = 1'b0;
                    end else begin
                        stall_cnt   = 0;
                        gcd_ready_i = 1'b1;
                        m_busy      = 1'b1;
                        m_done      = 1'b0;
                        m_delay     = delay_cfg;
                        m_res       = ref_gcd(gcd_a_o, gcd_b_o);
                    end
                end else begin
                    gcd_ready_i = 1'b0;
                end
            end
        end
    end

    // One full operation starting from an IDLE cycle. Called just after a
    // falling edge; returns on the falling edge at which the DUT is IDLE again.
    task automatic serve_one(input int hold, input bit nonowner, output int who,
                             output logic [W-1:0] res);
        int           g;
        int           issue_n;
        int           exp_last;
        bit           got;
        logic [W-1:0] a, b, er;
        logic [N-1:0] oh;
        drive_reqs();
        #1;
        g   = rr_pick();
        who = g;
        res = '0;
        if (g < 0) begin
            chk("ready_none", 64'(req_ready_o), 64'd0);
            return;
        end
        oh = oh_of(g);
        chk("grant", 64'(req_ready_o), 64'(oh));
        chk("busy_idle", 64'(busy_o), 64'd0);
        a = pend_a[g];
        b = pend_b[g];
        er = ref_gcd(a, b);
        pend_v[g] = 1'b0;
        exp_last = (delay_cfg + 1 > 65535) ? 65535 : delay_cfg + 1;
        issue_n = 0;
        got = 1'b0;
        for (int c = 0; c < delay_cfg + stall_cfg + 50 && !got; c++) begin
            @(negedge clk);
            drive_reqs();
            #1;
            if (c == 0) begin
                chk("gcd_v_t1", 64'(gcd_v_o), 64'd1);
                chk("owner", 64'(owner_o), 64'(g));
            end
            if (gcd_v_o) begin
                issue_n++;
                chk("gcd_a_hold", 64'(gcd_a_o), 64'(a));
                chk("gcd_b_hold", 64'(gcd_b_o), 64'(b));
            end
            chk("no_ready_busy", 64'(req_ready_o), 64'd0);
            chk("busy", 64'(busy_o), 64'd1);
            if (resp_v_o != '0) got = 1'b1;
        end
        chk("resp_seen", 64'(got), 64'd1);
        chk("resp_v", 64'(resp_v_o), 64'(oh));
        chk("resp_data", 64'(resp_data_o), 64'(er));
        chk("last_cycles", 64'(last_cycles_o), 64'(exp_last));
        chk("issue_cycles", 64'(issue_n), 64'(stall_cfg + 1));
        res = resp_data_o;
        for (int h = 0; h < hold; h++) begin
            resp_yumi_i = nonowner ? ~oh : '0;
            @(negedge clk);
            drive_reqs();
            #1;
            chk("bp_resp_v", 64'(resp_v_o), 64'(oh));
            chk("bp_resp_data", 64'(resp_data_o), 64'(er));
            chk("bp_no_ready", 64'(req_ready_o), 64'd0);
            chk("bp_busy", 64'(busy_o), 64'd1);
        end
        resp_yumi_i = oh;
        @(negedge clk);
        resp_yumi_i = '0;
        ptr_m = (g + 1) % N;
        drive_reqs();
    endtask

    vec_t         vecs [5];
    int           ord_who [5];
    logic [W-1:0] ord_res [5];
    int           who;
    logic [W-1:0] res;

    initial begin
        vecs[0] = '{2, 32'd12,         32'd18,         1, 0, 32'd6};
        vecs[1] = '{1, 32'd7,          32'd0,          0, 0, 32'd7};
        vecs[2] = '{3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  3, 0, 32'hFFFF_FFFF};
        vecs[3] = '{0, 32'd0,          32'd9,          0, 5, 32'd9};
        vecs[4] = '{2, 32'd1071,       32'd462,        4, 2, 32'd21};
        ord_who = '{0, 1, 2, 3, 0};
        ord_res = '{32'd2, 32'd3, 32'd5, 32'd1, 32'd4};

        pend_v = '0;
        for (int i = 0; i < N; i++) begin
            pend_a[i] = '0;
            pend_b[i] = '0;
        end
        ptr_m = 0;
        delay_cfg = 2;
        stall_cfg = 0;
        resp_yumi_i = '0;
        req_v_i = '0;
        req_a_i = '0;
        req_b_i = '0;

        // Reset with all four requesters already valid.
        set_req(0, 32'd4, 32'd6);
        set_req(1, 32'd9, 32'd6);
        set_req(2, 32'd10, 32'd15);
        set_req(3, 32'd7, 32'd5);
        reset_n_i = 1'b0;
        drive_reqs();
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready", 64'(req_ready_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_resp_v", 64'(resp_v_o), 64'd0);
        chk("rst_resp_data", 64'(resp_data_o), 64'd0);
        chk("rst_gcd_v", 64'(gcd_v_o), 64'd0);
        chk("rst_gcd_yumi", 64'(gcd_yumi_o), 64'd0);
        chk("rst_owner", 64'(owner_o), 64'd0);
        chk("rst_last", 64'(last_cycles_o), 64'd0);
        @(negedge clk);
        reset_n_i = 1'b1;

        // All simultaneous; requester 0 re-requests after its turn.
        for (int k = 0; k < 5; k++) begin
            serve_one(0, 1'b0, who, res);
            chk("order_who", 64'(who), 64'(ord_who[k]));
            chk("order_res", 64'(res), 64'(ord_res[k]));
            if (k == 0) set_req(0, 32'd8, 32'd12);
        end

        // Single-operation vectors, including boundary operands and a stall.
        for (int k = 0; k < 5; k++) begin
            delay_cfg = vecs[k].dly;
            stall_cfg = vecs[k].stl;
            set_req(vecs[k].req, vecs[k].a, vecs[k].b);
            serve_one(0, 1'b0, who, res);
            chk("vec_who", 64'(who), 64'(vecs[k].req));
            chk("vec_res", 64'(res), 64'(vecs[k].res));
        end
        stall_cfg = 0;

        // Response backpressure for 10 cycles with yumi on non-owner bits.
        delay_cfg = 1;
        set_req(1, 32'd100, 32'd75);
        serve_one(10, 1'b1, who, res);
        chk("bp_res", 64'(res), 64'd25);

        // Reset pulse while the operation sits in WAIT.
        delay_cfg = 20;
        set_req(1, 32'd21, 32'd14);
        drive_reqs();
        #1;
        chk("mid_grant", 64'(req_ready_o), 64'(oh_of(1)));
        pend_v[1] = 1'b0;
        repeat (3) begin
            @(negedge clk);
            drive_reqs();
        end
        reset_n_i = 1'b0;
        req_v_i = 4'b0100;
        @(negedge clk);
        #1;
        chk("mid_busy", 64'(busy_o), 64'd0);
        chk("mid_resp_v", 64'(resp_v_o), 64'd0);
        chk("mid_last", 64'(last_cycles_o), 64'd0);
        chk("mid_owner", 64'(owner_o), 64'd0);
        chk("mid_gcd_v", 64'(gcd_v_o), 64'd0);
        chk("mid_ready_in_rst", 64'(req_ready_o), 64'd0);
        reset_n_i = 1'b1;
        req_v_i = '0;
        ptr_m = 0;
        repeat (5) begin
            @(negedge clk);
            #1;
            chk("mid_no_resp", 64'(resp_v_o), 64'd0);
        end
        delay_cfg = 2;
        set_req(3, 32'd48, 32'd36);
        serve_one(1, 1'b0, who, res);
        chk("mid_after_res", 64'(res), 64'd12);

        // Randomized traffic against the reference model.
        for (int it = 0; it < 20; it++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend_v[i] && $urandom_range(0, 1) == 1)
                    set_req(i, W'($urandom_range(0, 300)), W'($urandom_range(0, 300)));
            end
            if (pend_v == '0) set_req(int'($urandom_range(0, N - 1)), W'($urandom_range(1, 500)), W'($urandom_range(1, 500)));
            delay_cfg = int'($urandom_range(0, 6));
            stall_cfg = int'($urandom_range(0, 3));
            serve_one(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), who, res);
        end

        // Counter saturation with a very slow gcd unit.
        pend_v = '0;
        stall_cfg = 0;
        delay_cfg = 70000;
        set_req(0, 32'd35, 32'd14);
        serve_one(0, 1'b0, who, res);
        chk("sat_last", 64'(last_cycles_o), 64'hFFFF);
        chk("sat_res", 64'(res), 64'd7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
